// File: rtl/mpi_link_pkg.sv
// Shared definitions for the credit-based MPI link (sender_mpi and mpi_credit_receiver).
package mpi_link_pkg;

  localparam int MPI_DATA_W = 64;

  typedef logic [MPI_DATA_W-1:0] mpi_word_t;

endpackage

// File: rtl/mpi_rx_fifo.sv
// Receive buffer for the MPI link: storage, wrapping pointers, occupancy and push/pop.
// With MPI_RX_OVF_CHECK_EN defined an extra 'dropped' output flags a rejected push.
module mpi_rx_fifo
  import mpi_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = MPI_DATA_W,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
`ifdef MPI_RX_OVF_CHECK_EN
  output logic             dropped,
`endif
  output logic             popped
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             wr_en_s;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  assign pop_s   = pop_req & ~empty_s;
  // A push into a full buffer is only accepted when a pop frees a slot on the same edge.
  assign wr_en_s = push & (~full_s | pop_s);

  // Occupancy next-state from accepted push and pop.
  always_comb begin
    count_nxt_s = count_r;
    if (wr_en_s & ~pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s & ~wr_en_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  assign valid  = ~empty_s;
  assign rdata  = mem_r[rd_ptr_r];
  assign count  = count_r;
  assign popped = pop_s;
`ifdef MPI_RX_OVF_CHECK_EN
  assign dropped = push & full_s & ~pop_s;
`endif

endmodule

// File: rtl/mpi_credit_receiver.sv
// Receive endpoint of the valid/data/yummy credit link: buffers words and returns credits.
// Optional feature macro: MPI_RX_OVF_CHECK_EN enables the sticky overflow flag and report.
module mpi_credit_receiver
  import mpi_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = MPI_DATA_W,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             yummy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  logic [CW-1:0] pend_r;
  logic [CW-1:0] pend_nxt_s;
  logic          yummy_r;
  logic          yummy_nxt_s;
  logic          popped_s;
`ifdef MPI_RX_OVF_CHECK_EN
  logic          dropped_s;
  logic          overflow_r;
`endif

  mpi_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .push    (valid_i),
    .wdata   (data_i),
    .pop_req (ready_i),
    .valid   (valid_o),
    .rdata   (data_o),
    .count   (count_o),
`ifdef MPI_RX_OVF_CHECK_EN
    .dropped (dropped_s),
`endif
    .popped  (popped_s)
  );

  // Credit drain: a pop either feeds an emission directly or queues behind pending credits.
  always_comb begin
    yummy_nxt_s = (pend_r != {CW{1'b0}}) | popped_s;
    pend_nxt_s  = pend_r;
    if (popped_s == yummy_nxt_s) begin
      pend_nxt_s = pend_r;
    end else if (yummy_nxt_s) begin
      pend_nxt_s = pend_r - CW'(1);
    end else begin
      pend_nxt_s = pend_r + CW'(1);
    end
  end

  // Pending-credit counter reloads DEPTH on reset, which is the initial advertisement.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_r  <= CW'(DEPTH);
      yummy_r <= 1'b0;
    end else begin
      pend_r  <= pend_nxt_s;
      yummy_r <= yummy_nxt_s;
    end
  end

  assign yummy_o = yummy_r;

`ifdef MPI_RX_OVF_CHECK_EN
  // Sticky overflow flag, set when the sender pushes into a full buffer with no pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_r <= 1'b0;
    end else if (dropped_s) begin
      overflow_r <= 1'b1;
      $error("mpi_credit_receiver: credit overflow, dropped word %h at count %0d", data_i, count_o);
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign overflow_o = overflow_r;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_mpi_credit_receiver.sv
// Self-checking bench for mpi_credit_receiver: queue-based reference model plus directed checks.
module tb_mpi_credit_receiver;
  import mpi_link_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef MPI_RX_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rstn_i  = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  mpi_word_t     data_i  = '0;
  logic          yummy_o;
  logic          valid_o;
  mpi_word_t     data_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  mpi_credit_receiver #(.DEPTH(DEPTH), .WIDTH(MPI_DATA_W)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .yummy_o    (yummy_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a word queue and a credit count owed to the sender.
  mpi_word_t q[$];
  int        m_pend  = DEPTH;
  bit        m_yummy = 1'b0;
  bit        m_ovf   = 1'b0;

  always @(posedge clk or negedge rstn_i) begin
    bit pop;
    if (!rstn_i) begin
      q.delete();
      m_pend  = DEPTH;
      m_yummy = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      pop     = (q.size() != 0) && ready_i;
      m_yummy = (m_pend != 0) || pop;
      m_pend  = m_pend + (pop ? 1 : 0) - (m_yummy ? 1 : 0);
      if (pop) void'(q.pop_front());
      if (valid_i) begin
        if (q.size() < DEPTH) q.push_back(data_i);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_yummy", 64'(yummy_o), 64'(m_yummy));
    chk("m_valid", 64'(valid_o), 64'(q.size() != 0));
    chk("m_count", 64'(count_o), 64'(q.size()));
    chk("m_ovf", 64'(overflow_o), 64'(OVF_EN & m_ovf));
    if (q.size() != 0) chk("m_data", data_o, q[0]);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push4(input mpi_word_t a, input mpi_word_t b, input mpi_word_t c, input mpi_word_t d);
    mpi_word_t w[4];
    w = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = w[i];
      step();
      chk("fill_count", 64'(count_o), 64'(i + 1));
    end
    valid_i = 1'b0;
  endtask

  task automatic drain4(input string name, input mpi_word_t a, input mpi_word_t b, input mpi_word_t c, input mpi_word_t d);
    mpi_word_t w[4];
    w = '{a, b, c, d};
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk(name, data_o, w[i]);
      step();
      chk("drain_yummy", 64'(yummy_o), 64'd1);
    end
    ready_i = 1'b0;
    step();
    chk("drain_count", 64'(count_o), 64'd0);
    chk("drain_yummy_end", 64'(yummy_o), 64'd0);
  endtask

  initial begin
    // Reset values and initial credit advertisement.
    repeat (2) step();
    chk("rst_yummy", 64'(yummy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("adv_yummy", 64'(yummy_o), 64'd1);
    end
    step();
    chk("adv_yummy_end", 64'(yummy_o), 64'd0);
    chk("adv_count", 64'(count_o), 64'd0);

    // Three pushes with the consumer stalled.
    valid_i = 1'b1;
    data_i  = 64'hA5;
    step();
    chk("p1_count", 64'(count_o), 64'd1);
    chk("p1_valid", 64'(valid_o), 64'd1);
    chk("p1_data", data_o, 64'hA5);
    data_i = 64'hB6;
    step();
    chk("p2_count", 64'(count_o), 64'd2);
    data_i = 64'hC7;
    step();
    chk("p3_count", 64'(count_o), 64'd3);
    chk("p3_yummy", 64'(yummy_o), 64'd0);
    chk("p3_head", data_o, 64'hA5);
    data_i = 64'hD8;
    step();
    chk("p4_count", 64'(count_o), 64'd4);
    valid_i = 1'b0;
    drain4("d1_data", 64'hA5, 64'hB6, 64'hC7, 64'hD8);

    // Push and pop on the same edge while full.
    push4(64'h1, 64'h2, 64'h3, 64'h4);
    valid_i = 1'b1;
    data_i  = 64'hEE;
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("pp_count", 64'(count_o), 64'd4);
    chk("pp_head", data_o, 64'h2);
    drain4("pp_data", 64'h2, 64'h3, 64'h4, 64'hEE);

    // Overflow: push while full with no pop is dropped.
    push4(64'h11, 64'h22, 64'h33, 64'h44);
    valid_i = 1'b1;
    data_i  = 64'hFF;
    step();
    valid_i = 1'b0;
    chk("ovf_count", 64'(count_o), 64'd4);
    chk("ovf_flag", 64'(overflow_o), 64'(OVF_EN));
    step();
    chk("ovf_sticky", 64'(overflow_o), 64'(OVF_EN));
    drain4("ovf_data", 64'h11, 64'h22, 64'h33, 64'h44);
    chk("ovf_hold", 64'(overflow_o), 64'(OVF_EN));

    // Mid-operation reset with count=2 and one credit still pending.
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
    chk("r2_ovf", 64'(overflow_o), 64'd0);
    step();
    valid_i = 1'b1;
    data_i  = 64'h61;
    step();
    data_i = 64'h62;
    step();
    valid_i = 1'b0;
    chk("r2_count_pre", 64'(count_o), 64'd2);
    chk("r2_yummy_pre", 64'(yummy_o), 64'd1);
    rstn_i = 1'b0;
    #1;
    chk("r2_valid_async", 64'(valid_o), 64'd0);
    chk("r2_count_async", 64'(count_o), 64'd0);
    chk("r2_yummy_async", 64'(yummy_o), 64'd0);
    step();
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r2_adv_yummy", 64'(yummy_o), 64'd1);
    end
    step();
    chk("r2_adv_end", 64'(yummy_o), 64'd0);
    chk("r2_count", 64'(count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mpi_credit_receiver.md
# mpi_credit_receiver

Receive endpoint of the credit-based valid/data/yummy link driven by `sender_mpi`. It captures each 64-bit word the sender asserts, buffers up to `DEPTH` words, and presents them downstream on a valid/ready port. It returns one `yummy_o` credit pulse per word drained, and advertises its initial `DEPTH` credits after reset. It sits between the link wire bundle in a rank's top level and the rank-local consumer logic.

## Interface
- `DEPTH`, 4 — buffer entries, equal to the credits advertised to the sender; must be ≥ 2.
- `WIDTH`, 64 — data width in bits; equals `MPI_DATA_W`.

Ports:
- `clk_i`  in  1 — single clock; all state updates on the rising edge.
- `rstn_i`  in  1 — reset, asynchronous, active-low.
- `valid_i`  in  1 — link word present this cycle; one word per cycle asserted.
- `data_i`  in  WIDTH — link word.
- `yummy_o`  out  1 — registered credit-return pulse to the sender; one credit per high cycle.
- `valid_o`  out  1 — buffer non-empty; head word on `data_o`.
- `data_o`  out  WIDTH — head-of-buffer word.
- `ready_i`  in  1 — consumer accepts the head word when `valid_o & ready_i`.
- `count_o`  out  $clog2(DEPTH+1) — current occupancy.
- `overflow_o`  out  1 — sticky overflow flag; see Configuration.

## Operation
- Push: `valid_i` high → `data_i` is written at the write pointer.
- Pop: `valid_o & ready_i` → the read pointer advances.
- Push and pop in the same cycle: both take effect and `count_o` is unchanged. This holds at full too: a push while full with a same-cycle pop is accepted.
- Push while full with no pop: the word is dropped and state is unchanged. This is overflow; the sender has violated credits.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Non-power-of-two `DEPTH` wraps explicitly from `DEPTH-1` to 0.
- Pending-credit counter `pend`, width `$clog2(DEPTH+1)`:
  - reset value `DEPTH`;
  - +1 per pop;
  - −1 per cycle in which `yummy_o` is driven high.
  - Pop and emit in the same cycle leave it unchanged.
  - Credit conservation guarantees `pend` ≤ `DEPTH`.
- `yummy_o` next-state = (`pend` != 0) or (pop this cycle). Emission and decrement happen in the same edge, so draining is one credit per cycle, back-to-back.
- Initial advertisement therefore needs no separate state. After reset, `DEPTH` consecutive `yummy_o` pulses are issued, plus any pops that occur meanwhile.
- Pops during the advertisement extend the pulse train; no credit is lost or merged.

## Timing
- Reset values:
  - `yummy_o`=0, `valid_o`=0, `count_o`=0, `overflow_o`=0, `data_o`=0.
  - Pointers 0; `pend`=`DEPTH`.
- Reset assertion mid-operation clears the buffer contents' visibility (`valid_o`=0) immediately and asynchronously. It also reloads `pend`=`DEPTH`, so the sender is re-credited after release.
- First `yummy_o` high: the first rising edge after `rstn_i` deasserts.
- Push-to-`valid_o` latency is 1 cycle: a word sampled at edge N is visible after edge N.
- `data_o` is driven from the storage array indexed by the read pointer. It is combinational from registers only, with no path from `valid_i`.
- Pop-to-`yummy_o` latency is 1 cycle when `pend`=0, otherwise queued behind outstanding credits.
- `count_o` updates on the same edge as push or pop.

## Configuration
- Macro `MPI_RX_OVF_CHECK_EN`.
  - Defined: `overflow_o` is set on the first overflow event and held until reset, and a simulation `$error` reports the dropped word and `count_o`.
  - Undefined: `overflow_o` is tied 0, with no checking logic and no message.
  - Drop behaviour is identical in both cases.

## Structure
- Package `mpi_link_pkg`:
  - `MPI_DATA_W`=64;
  - `typedef logic [MPI_DATA_W-1:0] mpi_word_t`.
  - `sender_mpi` is to import the same package.
- Sub-module `mpi_rx_fifo` holds storage, pointers, count, push/pop and full/empty.
- `mpi_credit_receiver` holds the credit counter, `yummy_o` register and overflow logic.

## Test plan
- Reset release with `valid_i`=0, `ready_i`=0 → `yummy_o` high exactly 4 consecutive cycles starting at the first edge, then 0; `count_o`=0.
- Push 0xA5, 0xB6, 0xC7 on 3 consecutive cycles with `ready_i`=0 → `count_o` 1,2,3; `valid_o` is high with `data_o`=0xA5 one cycle after the first push; no `yummy_o`.
- Fill to 4, then set `ready_i`=1 for 4 cycles → `data_o` is 0xA5,0xB6,0xC7,0xD8 in order; `yummy_o` is high 4 consecutive cycles, each starting one cycle after its pop; `count_o` ends at 0.
- Full (4) with push 0xEE and pop on the same cycle → `count_o` stays 4; 0xEE is later read as the last word.
- Full (4), push 0xFF with no pop → word dropped, `count_o`=4. With `MPI_RX_OVF_CHECK_EN`, `overflow_o`=1 until reset; without it, `overflow_o`=0.
- Assert `rstn_i` low for 1 cycle while `count_o`=2 and `pend`=1 → `valid_o`=0 immediately, `count_o`=0, then 4 fresh `yummy_o` pulses after release.
